branch_trace_driver: RTL and testbench

- Stimulus and scoring engine on the opposite end of the predictor interface.
- Replays a stored branch trace (pc, actual outcome) into a branch predictor one branch per cycle.
- Captures the predictor's registered prediction one cycle later and scores it against the outcome it issued.
- Sits beside gshare in the evaluation top level; replaces bench-side stimulus for on-chip accuracy runs.

---
 rtl/branch_eval_pkg.sv | 20 ++
 rtl/trace_mem.sv | 32 +++
 rtl/branch_trace_driver.sv | 145 ++++++++++++++
 tb/tb_branch_trace_driver.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_eval_pkg.sv
// Shared types for the on-chip branch predictor evaluation slice.
// Holds the replay FSM encoding, default widths and the trace entry layout.
package branch_eval_pkg;

    localparam int PC_W_DEF  = 8;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [PC_W_DEF-1:0] pc;
        logic                taken;
    } trace_entry_t;

endpackage

// File: rtl/trace_mem.sv
// Simple dual-port trace RAM: one write port, one registered read port.
// Read data appears one cycle after rd_en; no backpressure, writes always land.
module trace_mem #(
    parameter int ADDR_W = 8,
    parameter int DAT_W  = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DAT_W-1:0]  wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DAT_W-1:0]  rd_dat
);

    logic [DAT_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_dat;
    end

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset_n)
            rd_dat <= '0;
        else if (rd_en)
            rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/branch_trace_driver.sv
// Replays a stored branch trace into a predictor and scores its predictions; start->done = trace_len+3.
// No backpressure: one branch per cycle. TRACE_LOOP_EN adds loop_en for seamless multi-pass replay.
module branch_trace_driver
    import branch_eval_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int PC_W   = PC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PC_W-1:0]   wr_pc,
    input  logic              wr_taken,
    input  logic              start,
    input  logic [ADDR_W:0]   trace_len,
`ifdef TRACE_LOOP_EN
    input  logic              loop_en,
`endif
    output logic              br_valid,
    output logic [PC_W-1:0]   br_pc,
    output logic              br_taken,
    input  logic              pred_taken,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  correct_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
    } entry_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   len;
    logic              pass_end;
    logic              v_d;
    logic              t_d;
    logic              mem_we;
    logic              rd_en;
    logic              last;
    logic              loop_now;
    entry_t            rd_entry;

`ifdef TRACE_LOOP_EN
    assign loop_now = loop_en;
`else
    assign loop_now = 1'b0;
`endif

    assign mem_we = wr_en && (state == IDLE || state == DONE);
    assign rd_en  = (state == RUN) && !pass_end;
    assign last   = ({1'b0, ptr} == len - {{ADDR_W{1'b0}}, 1'b1});

    trace_mem #(
        .ADDR_W (ADDR_W),
        .DAT_W  (PC_W + 1)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (mem_we),
        .wr_addr (wr_addr),
        .wr_dat  ({wr_pc, wr_taken}),
        .rd_en   (rd_en),
        .rd_addr (ptr),
        .rd_dat  (rd_entry)
    );

    // The RAM read register doubles as the issue register for pc/outcome.
    assign br_pc    = rd_entry.pc;
    assign br_taken = rd_entry.taken;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            ptr              <= '0;
            len              <= '0;
            pass_end         <= 1'b0;
            br_valid         <= 1'b0;
            v_d              <= 1'b0;
            t_d              <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            branch_count     <= '0;
            correct_count    <= '0;
            mispredict_count <= '0;
        end else begin
            v_d <= br_valid;
            t_d <= br_taken;
            // pred_taken refers to the branch issued one cycle before v_d.
            if (v_d) begin
                branch_count <= sat_inc(branch_count);
                if (pred_taken == t_d)
                    correct_count <= sat_inc(correct_count);
                else
                    mispredict_count <= sat_inc(mispredict_count);
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        branch_count     <= '0;
                        correct_count    <= '0;
                        mispredict_count <= '0;
                        ptr              <= '0;
                        len              <= trace_len;
                        pass_end         <= 1'b0;
                        busy             <= (trace_len != '0);
                        done             <= (trace_len == '0);
                        state            <= (trace_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!pass_end) begin
                        br_valid <= 1'b1;
                        if (last && loop_now) begin
                            ptr <= '0;
                        end else begin
                            ptr <= ptr + 1'b1;
                            if (last)
                                pass_end <= 1'b1;
                        end
                    end else begin
                        br_valid <= 1'b0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_trace_driver.sv
// Directed bench for branch_trace_driver with a configurable stub predictor.
module tb_branch_trace_driver;

    localparam int ADDR_W = 8;
    localparam int PC_W   = 8;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PC_W-1:0]   wr_pc;
    logic              wr_taken;
    logic              start;
    logic [ADDR_W:0]   trace_len;
`ifdef TRACE_LOOP_EN
    logic              loop_en = 1'b0;
`endif
    logic              br_valid;
    logic [PC_W-1:0]   br_pc;
    logic              br_taken;
    logic              pred_taken;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  branch_count;
    logic [CNT_W-1:0]  correct_count;
    logic [CNT_W-1:0]  mispredict_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcnt = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int start_cyc = 0;
    int lat = 0;
    int bad = 0;
    int guard = 0;
    logic [1:0] mode = 2'd0;
    logic [PC_W-1:0] pcs[$];
    logic [7:0] pat;

    branch_trace_driver #(.ADDR_W(ADDR_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_pc            (wr_pc),
        .wr_taken         (wr_taken),
        .start            (start),
        .trace_len        (trace_len),
`ifdef TRACE_LOOP_EN
        .loop_en          (loop_en),
`endif
        .br_valid         (br_valid),
        .br_pc            (br_pc),
        .br_taken         (br_taken),
        .pred_taken       (pred_taken),
        .busy             (busy),
        .done             (done),
        .branch_count     (branch_count),
        .correct_count    (correct_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    // Stub predictor: registered prediction for the branch presented last cycle.
    // mode 0 = always right, 1 = always wrong, 2 = always not-taken.
    always @(posedge clk) begin
        case (mode)
            2'd1:    pred_taken <= ~br_taken;
            2'd2:    pred_taken <= 1'b0;
            default: pred_taken <= br_taken;
        endcase
    end

    // Issue monitor, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (br_valid) begin
            vcnt++;
            if (vcnt == 1)
                first_cyc = cyc;
            last_cyc = cyc;
            pcs.push_back(br_pc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [PC_W-1:0] pc, input logic tk);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_addr  = addr[ADDR_W-1:0];
        wr_pc    = pc;
        wr_taken = tk;
        @(negedge clk);
        wr_en    = 1'b0;
    endtask

    task automatic launch(input int len);
        @(negedge clk);
        start     = 1'b1;
        trace_len = len[ADDR_W:0];
        vcnt      = 0;
        pcs.delete();
        start_cyc = cyc;
        @(negedge clk);
        start     = 1'b0;
        lat       = 1;
    endtask

    task automatic wait_done();
        while (!done && lat < 600) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_pc     = '0;
        wr_taken  = 1'b0;
        start     = 1'b0;
        trace_len = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", br_valid, 0);
        check("rst_pc", br_pc, 0);
        check("rst_branch", branch_count, 0);
        check("rst_correct", correct_count, 0);
        check("rst_mispred", mispredict_count, 0);
        reset_n = 1'b1;

        pat = 8'hA1;
        for (int i = 0; i < 10; i++)
            wr(i, 8'h10 + 8'(i), (i < 8) ? pat[i] : 1'b1);

        // 8 entries, predictor always not-taken: 3 taken -> 3 mispredicts.
        mode = 2'd2;
        launch(8);
        wait_done();
        check("t8_latency", lat, 11);
        check("t8_issues", vcnt, 8);
        check("t8_first_issue", first_cyc - start_cyc, 2);
        check("t8_contig", last_cyc - first_cyc + 1, 8);
        check("t8_branch", branch_count, 8);
        check("t8_correct", correct_count, 5);
        check("t8_mispred", mispredict_count, 3);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (pcs[i] !== 8'h10 + 8'(i)) bad++;
        check("t8_pc_order", bad, 0);

        // Always-wrong predictor over 4 entries.
        mode = 2'd1;
        launch(4);
        wait_done();
        check("t4_mispred", mispredict_count, 4);
        check("t4_correct", correct_count, 0);
        check("t4_branch", branch_count, 4);
        check("t4_issues", vcnt, 4);
        check("t4_contig", last_cyc - first_cyc + 1, 4);

        // Zero-length trace.
        mode = 2'd0;
        launch(0);
        wait_done();
        check("t0_latency", lat, 1);
        check("t0_branch", branch_count, 0);
        check("t0_correct", correct_count, 0);
        check("t0_mispred", mispredict_count, 0);
        repeat (3) @(negedge clk);
        check("t0_issues", vcnt, 0);

        // Reset in the middle of a 10-branch run.
        launch(10);
        guard = 0;
        while (vcnt < 5 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("rm_reached5", vcnt, 5);
        reset_n = 1'b0;
        @(negedge clk);
        check("rm_busy", busy, 0);
        check("rm_done", done, 0);
        check("rm_valid", br_valid, 0);
        check("rm_branch", branch_count, 0);
        check("rm_correct", correct_count, 0);
        check("rm_mispred", mispredict_count, 0);
        reset_n = 1'b1;
        launch(4);
        wait_done();
        check("rm_replay_pc0", pcs[0], 8'h10);
        check("rm_replay_correct", correct_count, 4);

        // Write and start while running are both dropped.
        launch(8);
        @(negedge clk);
        lat++;
        start     = 1'b1;
        trace_len = 9'd2;
        wr_en     = 1'b1;
        wr_addr   = 8'd2;
        wr_pc     = 8'hAA;
        wr_taken  = 1'b0;
        @(negedge clk);
        lat++;
        start     = 1'b0;
        wr_en     = 1'b0;
        wait_done();
        check("ig_latency", lat, 11);
        check("ig_branch", branch_count, 8);
        launch(3);
        wait_done();
        check("ig_issues", vcnt, 3);
        check("ig_addr2_pc", pcs[2], 8'h12);
        check("ig_addr2_correct", correct_count, 3);

        // Full-depth trace: 256 issues, pointer wraps without an extra issue.
        for (int i = 0; i < 256; i++)
            wr(i, 8'(i), 1'(i & 1));
        mode = 2'd1;
        launch(256);
        wait_done();
        repeat (4) @(negedge clk);
        check("full_latency", lat, 259);
        check("full_issues", vcnt, 256);
        check("full_branch", branch_count, 256);
        check("full_mispred", mispredict_count, 256);
        check("full_last_pc", pcs[255], 8'hFF);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (pcs[i] !== 8'(i)) bad++;
        check("full_pc_order", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
